alu_writeback: RTL and testbench

//  Writeback stage directly downstream of the 20-bit ALU. Takes one ALU result per transaction over valid/ready and

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_writeback_reg_file.sv | 38 +++
 rtl/alu_writeback.sv | 151 +++++++++++++++
 tb/tb_alu_writeback.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared widths, status-register layout and state encodings for the ALU writeback stage.
package alu_pkg;

  localparam int unsigned WIDTH      = 20;
  localparam int unsigned HALF_WIDTH = WIDTH / 2;
  localparam int unsigned NREGS      = 16;
  localparam int unsigned AW         = $clog2(NREGS);

  // Status register bit positions {T,C,S,Z}
  localparam int unsigned SR_Z = 0;
  localparam int unsigned SR_S = 1;
  localparam int unsigned SR_C = 2;
  localparam int unsigned SR_T = 3;

  typedef enum logic [1:0] {
    SR_NONE  = 2'b00,
    SR_FLAGS = 2'b01,
    SR_LSR   = 2'b10,
    SR_XSR   = 2'b11
  } sr_op_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_WRITE_B = 1'b1
  } wb_state_e;

endpackage

// File: rtl/alu_writeback_reg_file.sv
// General register file: NREGS x WIDTH, two async read ports, one sync write
// port with a half-word enable (only the low HALF_WIDTH bits written when !full).
module reg_file
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             full,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr0,
  input  logic [AW-1:0]    rd_addr1,
  output logic [WIDTH-1:0] rd_data0,
  output logic [WIDTH-1:0] rd_data1
);

  logic [WIDTH-1:0] mem [NREGS];

  // Storage with async clear; half-word writes leave the upper half intact
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      if (full) begin
        mem[wr_addr] <= wr_data;
      end else begin
        mem[wr_addr][HALF_WIDTH-1:0] <= wr_data[HALF_WIDTH-1:0];
      end
    end
  end

  assign rd_data0 = mem[rd_addr0];
  assign rd_data1 = mem[rd_addr1];

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: commits ALU results to the register file, updates the
// status register, and sequences two-destination (swap) ops over two cycles.
// Optional feature macro: WB_FWD_EN (write-to-read forwarding on both read ports).
module alu_writeback
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic             in_wr_a,
  input  logic [AW-1:0]    in_dst_a,
  input  logic [WIDTH-1:0] in_res_a,
  input  logic             in_wr_b,
  input  logic [AW-1:0]    in_dst_b,
  input  logic [WIDTH-1:0] in_res_b,
  input  logic [1:0]       in_sr_op,
  input  logic [2:0]       in_flag_we,
  input  logic             in_zero,
  input  logic             in_sign,
  input  logic             in_carry,
  input  logic [AW-1:0]    rd_addr0,
  input  logic [AW-1:0]    rd_addr1,
  output logic [WIDTH-1:0] rd_data0,
  output logic [WIDTH-1:0] rd_data1,
  output logic [3:0]       sr,
  output logic             wb_done
);

  wb_state_e        state;
  logic [AW-1:0]    b_dst;
  logic [WIDTH-1:0] b_res;
  logic             b_mode;

  logic             accept;
  logic             wr_en;
  logic             wr_full;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [3:0]       sr_nxt;
  logic [WIDTH-1:0] rf_data0;
  logic [WIDTH-1:0] rf_data1;

  // in_ready is only ever high in IDLE, so accept implies IDLE
  assign accept = in_valid && in_ready;

  // Single write port: captured B write in WRITE_B, otherwise A on accept
  always_comb begin
    wr_en   = 1'b0;
    wr_full = in_mode;
    wr_addr = in_dst_a;
    wr_data = in_res_a;
    if (state == ST_WRITE_B) begin
      wr_en   = 1'b1;
      wr_full = b_mode;
      wr_addr = b_dst;
      wr_data = b_res;
    end else if (accept && in_wr_a) begin
      wr_en = 1'b1;
    end
  end

  // Next status register value for the incoming transaction
  always_comb begin
    sr_nxt = sr;
    case (sr_op_e'(in_sr_op))
      SR_FLAGS: begin
        if (in_flag_we[0]) sr_nxt[SR_Z] = in_zero;
        if (in_flag_we[1]) sr_nxt[SR_S] = in_sign;
        if (in_flag_we[2]) sr_nxt[SR_C] = in_carry;
        sr_nxt[SR_T] = sr[SR_T];
      end
      SR_LSR:  sr_nxt = in_res_a[3:0];
      SR_XSR:  sr_nxt = sr ^ in_res_a[3:0];
      default: sr_nxt = sr;
    endcase
  end

  // Control FSM with registered handshake, done pulse, SR and B capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      in_ready <= 1'b0;
      wb_done  <= 1'b0;
      sr       <= 4'b0;
      b_dst    <= '0;
      b_res    <= '0;
      b_mode   <= 1'b0;
    end else begin
      wb_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            sr     <= sr_nxt;
            b_dst  <= in_dst_b;
            b_res  <= in_res_b;
            b_mode <= in_mode;
            if (in_wr_b) begin
              state    <= ST_WRITE_B;
              in_ready <= 1'b0;
            end else begin
              wb_done <= 1'b1;
            end
          end
        end
        ST_WRITE_B: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
          wb_done  <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  reg_file u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .we       (wr_en),
    .full     (wr_full),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr0 (rd_addr0),
    .rd_addr1 (rd_addr1),
    .rd_data0 (rf_data0),
    .rd_data1 (rf_data1)
  );

`ifdef WB_FWD_EN
  // Forward the in-flight write, merged with the stored upper half in half-word mode
  always_comb begin
    rd_data0 = rf_data0;
    rd_data1 = rf_data1;
    if (wr_en && (wr_addr == rd_addr0)) begin
      rd_data0 = wr_full ? wr_data : {rf_data0[WIDTH-1:HALF_WIDTH], wr_data[HALF_WIDTH-1:0]};
    end
    if (wr_en && (wr_addr == rd_addr1)) begin
      rd_data1 = wr_full ? wr_data : {rf_data1[WIDTH-1:HALF_WIDTH], wr_data[HALF_WIDTH-1:0]};
    end
  end
`else
  assign rd_data0 = rf_data0;
  assign rd_data1 = rf_data1;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_mode;
  logic        in_wr_a;
  logic [3:0]  in_dst_a;
  logic [19:0] in_res_a;
  logic        in_wr_b;
  logic [3:0]  in_dst_b;
  logic [19:0] in_res_b;
  logic [1:0]  in_sr_op;
  logic [2:0]  in_flag_we;
  logic        in_zero;
  logic        in_sign;
  logic        in_carry;
  logic [3:0]  rd_addr0;
  logic [3:0]  rd_addr1;
  logic [19:0] rd_data0;
  logic [19:0] rd_data1;
  logic [3:0]  sr;
  logic        wb_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_writeback dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_wr_a    (in_wr_a),
    .in_dst_a   (in_dst_a),
    .in_res_a   (in_res_a),
    .in_wr_b    (in_wr_b),
    .in_dst_b   (in_dst_b),
    .in_res_b   (in_res_b),
    .in_sr_op   (in_sr_op),
    .in_flag_we (in_flag_we),
    .in_zero    (in_zero),
    .in_sign    (in_sign),
    .in_carry   (in_carry),
    .rd_addr0   (rd_addr0),
    .rd_addr1   (rd_addr1),
    .rd_data0   (rd_data0),
    .rd_data1   (rd_data1),
    .sr         (sr),
    .wb_done    (wb_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 0; in_mode = 1; in_wr_a = 0; in_dst_a = 0; in_res_a = 0;
    in_wr_b = 0; in_dst_b = 0; in_res_b = 0; in_sr_op = 0; in_flag_we = 0;
    in_zero = 0; in_sign = 0; in_carry = 0;
  endtask

  task automatic drive_a(input logic mode, input logic [3:0] dst, input logic [19:0] res);
    clear_inputs();
    in_valid = 1; in_mode = mode; in_wr_a = 1; in_dst_a = dst; in_res_a = res;
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    rd_addr0 = 0;
    rd_addr1 = 0;
    tick();
    tick();
    chk("rst_ready", 32'(in_ready), 32'h0);
    chk("rst_sr", 32'(sr), 32'h0);
    chk("rst_rd0", 32'(rd_data0), 32'h0);
    chk("rst_done", 32'(wb_done), 32'h0);
    rst = 0;
    tick();
    chk("ready_after_rst", 32'(in_ready), 32'h1);

    // Full-word write R3
    rd_addr0 = 3;
    drive_a(1'b1, 4'd3, 20'hABCDE);
    tick();
    clear_inputs();
    chk("full_r3", 32'(rd_data0), 32'hABCDE);
    chk("full_done", 32'(wb_done), 32'h1);
    chk("full_ready", 32'(in_ready), 32'h1);
    tick();
    chk("full_done_once", 32'(wb_done), 32'h0);

    // Half-word write preserves upper half
    rd_addr0 = 5;
    drive_a(1'b1, 4'd5, 20'hFFFFF);
    tick();
    drive_a(1'b0, 4'd5, 20'h00123);
    tick();
    clear_inputs();
    chk("half_r5", 32'(rd_data0), 32'hFFD23);

    // Swap R1/R2
    rd_addr0 = 1;
    rd_addr1 = 2;
    drive_a(1'b1, 4'd1, 20'h11111);
    in_wr_b = 1; in_dst_b = 2; in_res_b = 20'h22222;
    tick();
    // Offer a transaction during WRITE_B; it must be ignored
    drive_a(1'b1, 4'd9, 20'h12345);
    chk("swap_ready_low", 32'(in_ready), 32'h0);
    chk("swap_r1", 32'(rd_data0), 32'h11111);
    chk("swap_r2_pending", 32'(rd_data1), 32'h0);
    chk("swap_done_early", 32'(wb_done), 32'h0);
    tick();
    clear_inputs();
    chk("swap_r2", 32'(rd_data1), 32'h22222);
    chk("swap_done", 32'(wb_done), 32'h1);
    chk("swap_ready_back", 32'(in_ready), 32'h1);
    rd_addr0 = 9;
    chk("ignored_r9", 32'(rd_data0), 32'h0);

    // Same destination: B wins
    rd_addr0 = 4;
    drive_a(1'b1, 4'd4, 20'h0AAAA);
    in_wr_b = 1; in_dst_b = 4; in_res_b = 20'h0BBBB;
    tick();
    clear_inputs();
    chk("same_dst_a", 32'(rd_data0), 32'h0AAAA);
    tick();
    chk("same_dst_b", 32'(rd_data0), 32'h0BBBB);

    // B-only half-word write
    rd_addr0 = 5;
    clear_inputs();
    in_valid = 1; in_mode = 0; in_wr_b = 1; in_dst_b = 5; in_res_b = 20'h00000;
    tick();
    clear_inputs();
    chk("bonly_a_idle", 32'(rd_data0), 32'hFFD23);
    tick();
    chk("bonly_r5", 32'(rd_data0), 32'hFFC00);
    chk("bonly_done", 32'(wb_done), 32'h1);

    // Status register ops
    clear_inputs();
    in_valid = 1; in_sr_op = 2'b01; in_flag_we = 3'b001; in_zero = 1; in_sign = 1; in_carry = 1;
    tick();
    clear_inputs();
    chk("sr_flags_z", 32'(sr), 32'h1);
    in_valid = 1; in_sr_op = 2'b10; in_res_a = 20'h0000A;
    tick();
    clear_inputs();
    chk("sr_lsr", 32'(sr), 32'hA);
    in_valid = 1; in_sr_op = 2'b11; in_res_a = 20'h0000F; in_mode = 0;
    tick();
    clear_inputs();
    chk("sr_xsr", 32'(sr), 32'h5);
    in_valid = 1; in_sr_op = 2'b01; in_flag_we = 3'b010; in_zero = 0; in_sign = 1; in_carry = 0;
    tick();
    clear_inputs();
    chk("sr_flags_s", 32'(sr), 32'h7);

    // Read of the register being written in the same cycle
    rd_addr1 = 7;
    drive_a(1'b1, 4'd7, 20'h0F0F0);
`ifdef WB_FWD_EN
    chk("fwd_r7", 32'(rd_data1), 32'h0F0F0);
`else
    chk("nofwd_r7", 32'(rd_data1), 32'h0);
`endif
    tick();
    clear_inputs();
    chk("r7_after", 32'(rd_data1), 32'h0F0F0);

    // Reset in the middle of a swap drops the pending B write
    rd_addr0 = 8;
    rd_addr1 = 9;
    drive_a(1'b1, 4'd8, 20'h88888);
    in_wr_b = 1; in_dst_b = 9; in_res_b = 20'h99999;
    tick();
    clear_inputs();
    chk("mid_ready_low", 32'(in_ready), 32'h0);
    chk("mid_r8", 32'(rd_data0), 32'h88888);
    rst = 1;
    #1;
    chk("mid_rst_r8", 32'(rd_data0), 32'h0);
    chk("mid_rst_sr", 32'(sr), 32'h0);
    chk("mid_rst_ready", 32'(in_ready), 32'h0);
    tick();
    chk("mid_rst_r9", 32'(rd_data1), 32'h0);
    rst = 0;
    tick();
    chk("mid_ready_after", 32'(in_ready), 32'h1);
    chk("mid_r9_dropped", 32'(rd_data1), 32'h0);
    chk("mid_done_low", 32'(wb_done), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
